// File: rtl/voice_oscillator_bank_pkg.sv
// -----------------------------------------------------------------------------
// voice_oscillator_bank_pkg
//   Shared types and helpers for the voice oscillator bank.
//   MODE_TYPES : global play mode (OFF silences every voice, ON allows play).
//   mix_width  : width of the voice-count sum, sized so it cannot overflow.
// -----------------------------------------------------------------------------
package voice_oscillator_bank_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    // Bits needed to hold any count from 0 to nv inclusive.
    function automatic int mix_width(input int nv);
        return $clog2(nv + 1);
    endfunction

endpackage

// File: rtl/voice_oscillator_bank_if.sv
// -----------------------------------------------------------------------------
// voice_oscillator_bank_if
//   Bundles the control and status signals of the voice oscillator bank.
//   master : drives state/play/freq, observes tick/wave/active/done/mix
//   slave  : the oscillator bank itself
//   Signals:
//     state  - OFF/ON play mode
//     play   - per-voice note trigger
//     freq   - per-voice divider value, captured on trigger
//     tick   - per-voice one-cycle pulse at each period boundary
//     wave   - per-voice square wave
//     active - per-voice sounding flag
//     done   - per-voice one-cycle pulse on natural note expiry
//     mix    - number of wave bits high in the previous cycle
// -----------------------------------------------------------------------------
interface voice_oscillator_bank_if #(
    parameter int NUM_VOICES = 4,
    parameter int N          = 8
);
    import voice_oscillator_bank_pkg::*;

    localparam int MIX_W = mix_width(NUM_VOICES);

    MODE_TYPES                       state;
    logic [NUM_VOICES-1:0]           play;
    logic [NUM_VOICES-1:0][N-1:0]    freq;
    logic [NUM_VOICES-1:0]           tick;
    logic [NUM_VOICES-1:0]           wave;
    logic [NUM_VOICES-1:0]           active;
    logic [NUM_VOICES-1:0]           done;
    logic [MIX_W-1:0]                mix;

    modport master (
        output state, play, freq,
        input  tick, wave, active, done, mix
    );

    modport slave (
        input  state, play, freq,
        output tick, wave, active, done, mix
    );

endinterface

// File: rtl/tone_voice.sv
// -----------------------------------------------------------------------------
// tone_voice
//   One independent tone voice: a free-running period counter that divides
//   the clock by (freq+1), a square wave toggled at each period boundary and
//   a duration counter that ends the note after DURATION active cycles.
//   Ports:
//     clk, nRst - clock (rising edge) and asynchronous active-low reset
//     state     - OFF clears the voice immediately, ON allows play
//     play      - note trigger (also retriggers a sounding voice)
//     freq      - divider value, captured on trigger
//     tick      - one-cycle pulse at each period boundary
//     wave      - square wave, toggles on each tick
//     active    - voice is sounding
//     done      - one-cycle pulse when a note runs out on its own
//   All outputs are registered.
// -----------------------------------------------------------------------------
module tone_voice
    import voice_oscillator_bank_pkg::*;
#(
    parameter int N        = 8,
    parameter int DUR_W    = 24,
    parameter int DURATION = 10000000
) (
    input  logic         clk,
    input  logic         nRst,
    input  MODE_TYPES    state,
    input  logic         play,
    input  logic [N-1:0] freq,
    output logic         tick,
    output logic         wave,
    output logic         active,
    output logic         done
);

    localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(DURATION - 1);

    logic [N-1:0]     freq_p0;
    logic [N-1:0]     count_p0;
    logic [DUR_W-1:0] remaining_p0;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            freq_p0      <= '0;
            count_p0     <= '0;
            remaining_p0 <= '0;
            tick         <= 1'b0;
            wave         <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
        end else if (state == OFF) begin
            // Forced silence: no done pulse, captured freq is irrelevant
            // until the next trigger reloads it.
            count_p0     <= '0;
            remaining_p0 <= '0;
            tick         <= 1'b0;
            wave         <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
        end else if (play) begin
            // Trigger or retrigger; takes priority over expiry. wave keeps
            // its level so a retrigger does not glitch the output.
            freq_p0      <= freq;
            count_p0     <= '0;
            remaining_p0 <= DUR_LOAD;
            tick         <= 1'b0;
            active       <= 1'b1;
            done         <= 1'b0;
        end else if (active) begin
            if (remaining_p0 == '0) begin
                count_p0 <= '0;
                tick     <= 1'b0;
                wave     <= 1'b0;
                active   <= 1'b0;
                done     <= 1'b1;
            end else begin
                remaining_p0 <= remaining_p0 - DUR_W'(1);
                done         <= 1'b0;
                if (count_p0 == freq_p0) begin
                    count_p0 <= '0;
                    tick     <= 1'b1;
                    wave     <= ~wave;
                end else begin
                    count_p0 <= count_p0 + N'(1);
                    tick     <= 1'b0;
                end
            end
        end else begin
            count_p0 <= '0;
            tick     <= 1'b0;
            wave     <= 1'b0;
            done     <= 1'b0;
        end
    end

endmodule

// File: rtl/voice_oscillator_bank.sv
// -----------------------------------------------------------------------------
// voice_oscillator_bank
//   NUM_VOICES independent square-wave tone voices plus a registered count of
//   how many voice waves are high (one cycle late).
//   Ports:
//     clk  - clock, rising edge
//     nRst - asynchronous active-low reset
//     bus  - voice_oscillator_bank_if slave: state/play/freq in,
//            tick/wave/active/done/mix out
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
// -----------------------------------------------------------------------------
module voice_oscillator_bank
    import voice_oscillator_bank_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int N          = 8,
    parameter int DUR_W      = 24,
    parameter int DURATION   = 10000000
) (
    input logic                      clk,
    input logic                      nRst,
    voice_oscillator_bank_if.slave   bus
);

    localparam int MIX_W = mix_width(NUM_VOICES);

    logic [NUM_VOICES-1:0] tick_p0;
    logic [NUM_VOICES-1:0] wave_p0;
    logic [NUM_VOICES-1:0] active_p0;
    logic [NUM_VOICES-1:0] done_p0;
    logic [MIX_W-1:0]      mix_p1;

    function automatic logic [MIX_W-1:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [MIX_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum = sum + MIX_W'(v[i]);
        end
        return sum;
    endfunction

    // Stage p0: per-voice oscillators
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        tone_voice #(
            .N        (N),
            .DUR_W    (DUR_W),
            .DURATION (DURATION)
        ) u_voice (
            .clk    (clk),
            .nRst   (nRst),
            .state  (bus.state),
            .play   (bus.play[i]),
            .freq   (bus.freq[i]),
            .tick   (tick_p0[i]),
            .wave   (wave_p0[i]),
            .active (active_p0[i]),
            .done   (done_p0[i])
        );
    end

    // Stage p1: mix count of the registered waves
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mix_p1 <= '0;
        end else begin
            mix_p1 <= popcount(wave_p0);
        end
    end

    assign bus.tick   = tick_p0;
    assign bus.wave   = wave_p0;
    assign bus.active = active_p0;
    assign bus.done   = done_p0;
    assign bus.mix    = mix_p1;

endmodule

// File: tb/tb_voice_oscillator_bank.sv
module tb_voice_oscillator_bank;
    import voice_oscillator_bank_pkg::*;

    localparam int NV  = 4;
    localparam int DUR = 20;

    typedef struct packed {
        logic [3:0] tick;
        logic [3:0] wave;
        logic [3:0] active;
        logic [3:0] done;
        logic [2:0] mix;
    } exp_t;

    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    voice_oscillator_bank_if #(.NUM_VOICES(NV), .N(8)) bus ();

    voice_oscillator_bank #(
        .NUM_VOICES (NV),
        .N          (8),
        .DUR_W      (24),
        .DURATION   (DUR)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, expressed as cycles elapsed since the last trigger.
    bit       m_act  [NV];
    bit       m_wave [NV];
    bit       m_tick [NV];
    bit       m_done [NV];
    bit       m_wb   [NV];
    int       m_f    [NV];
    int       m_k    [NV];
    bit [2:0] m_mix;
    exp_t     sbq[$];
    exp_t     mon_e;

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_wave[i] = 0; m_tick[i] = 0; m_done[i] = 0;
            m_wb[i] = 0; m_f[i] = 0; m_k[i] = 0;
        end
        m_mix = '0;
    endfunction

    // Predict the outputs after the coming edge from the current inputs,
    // queue them, then advance past that edge.
    task automatic edge_step();
        exp_t     e;
        bit [3:0] pw;
        if (!nRst) begin
            model_clear();
        end else begin
            for (int i = 0; i < NV; i++) pw[i] = m_wave[i];
            m_mix = 3'($countones(pw));
            for (int i = 0; i < NV; i++) begin
                if (bus.state == OFF) begin
                    m_act[i] = 0; m_wave[i] = 0; m_tick[i] = 0; m_done[i] = 0;
                end else if (bus.play[i]) begin
                    m_act[i] = 1; m_f[i] = int'(bus.freq[i]); m_k[i] = 0;
                    m_wb[i] = m_wave[i]; m_tick[i] = 0; m_done[i] = 0;
                end else if (m_act[i]) begin
                    m_k[i]++;
                    m_done[i] = 0;
                    if (m_k[i] == DUR) begin
                        m_act[i] = 0; m_wave[i] = 0; m_tick[i] = 0; m_done[i] = 1;
                    end else begin
                        m_tick[i] = ((m_k[i] % (m_f[i] + 1)) == 0);
                        m_wave[i] = m_wb[i] ^ bit'((m_k[i] / (m_f[i] + 1)) % 2);
                    end
                end else begin
                    m_wave[i] = 0; m_tick[i] = 0; m_done[i] = 0;
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            e.tick[i]   = m_tick[i];
            e.wave[i]   = m_wave[i];
            e.active[i] = m_act[i];
            e.done[i]   = m_done[i];
        end
        e.mix = m_mix;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.play = '0;
        for (int c = 0; c < n; c++) edge_step();
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if ({bus.tick, bus.wave, bus.active, bus.done, bus.mix} !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t tick=%b/%b wave=%b/%b active=%b/%b done=%b/%b mix=%0d/%0d (got/exp)",
                         $time, bus.tick, mon_e.tick, bus.wave, mon_e.wave, bus.active, mon_e.active,
                         bus.done, mon_e.done, bus.mix, mon_e.mix);
            end
        end
    end

    task automatic test_reset();
        nRst = 1'b0;
        bus.state = ON;
        bus.play = '0;
        bus.freq = '0;
        model_clear();
        #1;
        checks++;
        if ({bus.tick, bus.wave, bus.active, bus.done, bus.mix} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.tick, bus.wave, bus.active, bus.done, bus.mix});
        end
        bus.play = 4'hF;
        bus.freq[0] = 8'd1;
        for (int c = 0; c < 2; c++) begin
            edge_step();
            checks++;
            if (bus.active !== 4'h0) begin
                errors++;
                $display("FAIL reset_play_ignored got=%b exp=0000", bus.active);
            end
        end
        bus.play = '0;
        nRst = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int cyc;
        for (int c = 0; c <= 22; c++) begin
            bus.play = (c == 0) ? 4'b0001 : 4'b0000;
            bus.freq[0] = 8'd3;
            edge_step();
            cyc = c + 1;
            checks++;
            if ({bus.active[0], bus.tick[0], bus.done[0]} !==
                {cyc <= 20, cyc == 5 || cyc == 9 || cyc == 13 || cyc == 17, cyc == 21}) begin
                errors++;
                $display("FAIL basic cyc=%0d act/tick/done got=%b%b%b", cyc, bus.active[0], bus.tick[0], bus.done[0]);
            end
            if (cyc == 21) begin
                checks++;
                if (bus.wave[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_wave_low got=%b exp=0", bus.wave[0]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_freq0();
        logic prev;
        bus.play = 4'b0010;
        bus.freq[1] = 8'd0;
        edge_step();
        prev = bus.wave[1];
        bus.play = '0;
        for (int cyc = 2; cyc <= 20; cyc++) begin
            edge_step();
            checks++;
            if (bus.tick[1] !== 1'b1 || bus.wave[1] === prev) begin
                errors++;
                $display("FAIL freq0 cyc=%0d tick=%b wave=%b prev_wave=%b exp tick=1 wave toggled",
                         cyc, bus.tick[1], bus.wave[1], prev);
            end
            prev = bus.wave[1];
        end
        idle(3);
    endtask

    task automatic test_retrigger();
        int cyc;
        for (int c = 0; c <= 33; c++) begin
            bus.play = (c == 0 || c == 10) ? 4'b0100 : 4'b0000;
            bus.freq[2] = (c == 0) ? 8'd7 : 8'd5;
            edge_step();
            cyc = c + 1;
            checks++;
            if ({bus.active[2], bus.tick[2], bus.done[2]} !==
                {cyc <= 30, cyc == 9 || cyc == 17 || cyc == 23 || cyc == 29, cyc == 31}) begin
                errors++;
                $display("FAIL retrigger cyc=%0d act/tick/done got=%b%b%b", cyc, bus.active[2], bus.tick[2], bus.done[2]);
            end
        end
    endtask

    task automatic test_expiry_play();
        int cyc;
        for (int c = 0; c <= 43; c++) begin
            bus.play = (c == 0 || c == 20) ? 4'b1000 : 4'b0000;
            bus.freq[3] = 8'd2;
            edge_step();
            cyc = c + 1;
            checks++;
            if ({bus.active[3], bus.done[3]} !== {cyc <= 40, cyc == 41}) begin
                errors++;
                $display("FAIL expiry_play cyc=%0d act/done got=%b%b", cyc, bus.active[3], bus.done[3]);
            end
        end
    endtask

    task automatic test_off();
        bus.play = 4'hF;
        bus.freq[0] = 8'd1; bus.freq[1] = 8'd2; bus.freq[2] = 8'd0; bus.freq[3] = 8'd3;
        edge_step();
        idle(6);
        bus.state = OFF;
        bus.play = 4'hF;
        for (int c = 0; c < 3; c++) begin
            edge_step();
            checks++;
            if ({bus.tick, bus.wave, bus.active, bus.done} !== 16'h0000) begin
                errors++;
                $display("FAIL off_clear got=%h exp=0000", {bus.tick, bus.wave, bus.active, bus.done});
            end
        end
        bus.state = ON;
        bus.play = '0;
        for (int c = 0; c < 3; c++) begin
            edge_step();
            checks++;
            if ({bus.active, bus.done} !== 8'h00) begin
                errors++;
                $display("FAIL off_stays_idle got=%h exp=00", {bus.active, bus.done});
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.play = 4'hF;
        bus.freq[0] = 8'd2; bus.freq[1] = 8'd1; bus.freq[2] = 8'd3; bus.freq[3] = 8'd0;
        edge_step();
        idle(6);
        @(negedge clk);
        #1;
        nRst = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({bus.tick, bus.wave, bus.active, bus.done, bus.mix} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_async got=%h exp=0", {bus.tick, bus.wave, bus.active, bus.done, bus.mix});
        end
        bus.play = 4'hF;
        edge_step();
        edge_step();
        bus.play = '0;
        nRst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            edge_step();
            checks++;
            if ({bus.active, bus.done} !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_idle got=%h exp=00", {bus.active, bus.done});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 120; c++) begin
            bus.state = ($urandom_range(0, 29) == 0) ? OFF : ON;
            for (int i = 0; i < NV; i++) begin
                bus.play[i] = ($urandom_range(0, 9) == 0);
                bus.freq[i] = 8'($urandom_range(0, 4));
            end
            edge_step();
        end
        bus.state = ON;
        idle(DUR + 3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_freq0();
        test_retrigger();
        test_expiry_play();
        test_off();
        test_reset_mid();
        test_random();
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/voice_oscillator_bank.md
VOICE_OSCILLATOR_BANK -- requirements
Module: voice_oscillator_bank

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4: number of independent tone voices (1..16).
REQ-002 The block SHALL have parameter N, default 8: width of each voice's frequency divider and period counter.
REQ-003 The block SHALL have parameter DUR_W, default 24: width of the per-voice duration counter.
REQ-004 The block SHALL have parameter DURATION, default 10000000: active cycles per note (1..2^DUR_W-1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port nRst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port state, input, MODE_TYPES: OFF silences all voices; ON enables play.
REQ-008 The block SHALL have port play, input, NUM_VOICES bits: per-voice note trigger, sampled every cycle.
REQ-009 The block SHALL have port freq, input, NUM_VOICES x N packed: per-voice divider value, captured on trigger.
REQ-010 The block SHALL have port tick, output, NUM_VOICES bits: one-cycle pulse at each period boundary.
REQ-011 The block SHALL have port wave, output, NUM_VOICES bits: square wave that toggles on each tick.
REQ-012 The block SHALL have port active, output, NUM_VOICES bits: voice is sounding.
REQ-013 The block SHALL have port done, output, NUM_VOICES bits: one-cycle pulse on natural note expiry.
REQ-014 The block SHALL have port mix, output, $clog2(NUM_VOICES+1) bits: count of wave bits currently high.

Function
REQ-015 Voices SHALL be fully independent; every rule below applies per voice i.
REQ-016 With state==ON and play[i]==1 at edge T, the voice SHALL capture freq[i], clear its period count to 0, load remaining=DURATION-1, and set active from T+1.
REQ-017 A play while already active (retrigger) SHALL reload freq, count and remaining as in REQ-016; wave SHALL keep its value; no done pulse.
REQ-018 While active, count SHALL increment each cycle; when count==captured freq, count SHALL return to 0 and tick SHALL assert and wave toggle on the next edge.
REQ-019 First tick SHALL appear freq+2 cycles after the sampling edge, then every freq+1 cycles; freq==0 SHALL give tick high every cycle and wave toggling every cycle.
REQ-020 remaining SHALL decrement once per active cycle; when an active voice has remaining==0 and no play, active, wave, tick and count SHALL clear at the next edge and done SHALL pulse for one cycle.
REQ-021 active SHALL therefore stay high exactly DURATION cycles per untouched note.
REQ-022 play coinciding with expiry (remaining==0) SHALL win: note restarts, no done.
REQ-023 state==OFF SHALL ignore play and clear active, wave, tick, count and remaining of all voices at the next edge without a done pulse.
REQ-024 An inactive voice SHALL hold tick=0, wave=0 and count=0.
REQ-025 mix SHALL be registered and equal the population count of wave from the previous cycle; the sum SHALL not overflow, with width per REQ-014.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 While nRst==0, tick, wave, active, done and mix SHALL all be 0, and internal count, remaining and captured freq SHALL be 0.
REQ-028 Reset asserted mid-note SHALL abort immediately without a done pulse; after release, voices SHALL stay idle until a new play.

Structure
REQ-029 The MODE_TYPES enum (OFF=1'b0, ON=1'b1) SHALL reside in the shared package, not in this module.
REQ-030 One sub-module, tone_voice, SHALL implement a single voice (REQ-016 to REQ-024), parametrised by N, DUR_W and DURATION, and be instantiated NUM_VOICES times by generate.
REQ-031 Popcount and the mix register SHALL live in the top level.

Verification (NUM_VOICES=4, N=8, DURATION=20)
REQ-032 Scenario: play[0] at edge 0 with freq=3 -> active[0] high cycles 1..20; tick[0] at cycles 5, 9, 13, 17; done[0] at cycle 21; wave[0] low again at 21.
REQ-033 Scenario: freq=0 on voice 1 -> tick[1] high every active cycle; wave[1] alternates each cycle.
REQ-034 Scenario: retrigger voice 2 at cycle 10 with freq=5 -> active continues to cycle 30; tick period becomes 6; single done at 31.
REQ-035 Scenario: play at the expiry cycle -> no done pulse; active stays high with no gap.
REQ-036 Scenario: all four voices active, state driven OFF -> all outputs 0 the next cycle, no done; play ignored while OFF.
REQ-037 Scenario: nRst pulsed low mid-note -> outputs 0 asynchronously; mix equals popcount(wave) delayed by one cycle throughout.
